compare_codes: RTL and testbench

Passcode comparator for the digital safe lock controller. Takes the 4-digit BCD code entered on the keypad and the scrambled stored passcode, descrambles the stored value according to a fixed nibble permutation (STORED_MASK), and reports whether the two codes are equal. Sits between the code-entry register and the lock FSM; its registered `match` output is the unlock qualifier.

---
 rtl/compare_codes.sv | 67 ++++++
 tb/tb_compare_codes.sv | 116 +++++++++++
 2 files changed

// File: rtl/compare_codes.sv
// rtl/compare_codes.sv - passcode comparator: descrambles the stored code and registers per-digit/overall match
module compare_codes #(
  parameter int                    NUM_DIGITS  = 4,
  parameter logic [4*NUM_DIGITS-1:0] STORED_MASK = 16'h2130
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] input_code,
  input  logic [4*NUM_DIGITS-1:0] stored_code,
  output logic                    match,
  output logic [NUM_DIGITS-1:0]   digit_match
);

  // A mask that is not a permutation would leave some logical digit undefined,
  // so such a configuration never reports a match.
  function automatic bit mask_is_perm(input logic [4*NUM_DIGITS-1:0] mask);
    bit [NUM_DIGITS-1:0] seen;
    int                  idx;
    seen         = '0;
    mask_is_perm = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      idx = int'(mask[4*k +: 4]);
      if (idx >= NUM_DIGITS) begin
        mask_is_perm = 1'b0;
      end else if (seen[idx]) begin
        mask_is_perm = 1'b0;
      end else begin
        seen[idx] = 1'b1;
      end
    end
  endfunction

  localparam bit PERM_OK = mask_is_perm(STORED_MASK);

  logic [4*NUM_DIGITS-1:0] descrambled;
  logic [NUM_DIGITS-1:0]   digit_eq;

  always_comb begin
    descrambled = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (int'(STORED_MASK[4*k +: 4]) < NUM_DIGITS) begin
        descrambled[4*int'(STORED_MASK[4*k +: 4]) +: 4] = stored_code[4*k +: 4];
      end
    end
  end

  // Every digit is evaluated each cycle; no early exit on the first mismatch.
  always_comb begin
    digit_eq = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_eq[i] = (input_code[4*i +: 4] == descrambled[4*i +: 4]) &&
                    (input_code[4*i +: 4] <= 4'd9) &&
                    (descrambled[4*i +: 4] <= 4'd9);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !PERM_OK) begin
      match       <= 1'b0;
      digit_match <= '0;
    end else begin
      match       <= &digit_eq;
      digit_match <= digit_eq;
    end
  end

endmodule

// File: tb/tb_compare_codes.sv
// tb/tb_compare_codes.sv - randomized self-checking bench for compare_codes
module tb_compare_codes;

  logic        clk;
  logic        rst;
  logic [15:0] input_code;
  logic [15:0] stored_code;
  logic        match;
  logic [3:0]  digit_match;

  int n_checks = 0;
  int n_fails  = 0;

  logic       prev_valid = 1'b0;
  logic       prev_m;
  logic [3:0] prev_dm;

  compare_codes dut (
    .clk        (clk),
    .rst        (rst),
    .input_code (input_code),
    .stored_code(stored_code),
    .match      (match),
    .digit_match(digit_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Physical nibble k of the stored word carries logical digit phys_to_log[k].
  function automatic logic [15:0] scramble(input logic [15:0] logical);
    int phys_to_log [4] = '{0, 3, 1, 2};
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) s[4*k +: 4] = logical[4*phys_to_log[k] +: 4];
    return s;
  endfunction

  function automatic logic [3:0] model_dm(input logic [15:0] in, input logic [15:0] logical);
    logic [3:0] dm;
    for (int i = 0; i < 4; i++) begin
      int a, b;
      a = int'(in[4*i +: 4]);
      b = int'(logical[4*i +: 4]);
      dm[i] = (a == b) && (a <= 9) && (b <= 9);
    end
    return dm;
  endfunction

  // Inputs change at the falling edge; outputs must hold until the next rising edge.
  task automatic step(input string tag, input logic r, input logic [15:0] in,
                      input logic [15:0] st, input logic exp_m, input logic [3:0] exp_dm);
    @(negedge clk);
    rst = r; input_code = in; stored_code = st;
    #1;
    if (prev_valid) begin
      check({tag, "_hold_match"}, {31'd0, match}, {31'd0, prev_m});
      check({tag, "_hold_dm"}, {28'd0, digit_match}, {28'd0, prev_dm});
    end
    @(posedge clk);
    #1;
    check({tag, "_match"}, {31'd0, match}, {31'd0, exp_m});
    check({tag, "_dm"}, {28'd0, digit_match}, {28'd0, exp_dm});
    prev_valid = 1'b1; prev_m = exp_m; prev_dm = exp_dm;
  endtask

  initial begin
    logic [15:0] logical, in;
    logic        r;
    logic [3:0]  dm;
    rst = 1'b1; input_code = 16'h9070; stored_code = 16'h0790;

    step("reset0", 1'b1, 16'h9070, 16'h0790, 1'b0, 4'b0000);
    step("reset1", 1'b1, 16'h9070, 16'h0790, 1'b0, 4'b0000);
    step("first", 1'b0, 16'h9070, 16'h0790, 1'b1, 4'b1111);
    step("correct", 1'b0, 16'h9070, 16'h0790, 1'b1, 4'b1111);
    step("wrong", 1'b0, 16'h1234, 16'h0790, 1'b0, 4'b0000);
    step("one_digit", 1'b0, 16'h9071, 16'h0790, 1'b0, 4'b1110);
    step("recover", 1'b0, 16'h9070, 16'h0790, 1'b1, 4'b1111);
    step("non_bcd", 1'b0, 16'h90A0, 16'h0A90, 1'b0, 4'b1101);

    for (int c = 0; c < 8; c++) begin
      r = (c == 4);
      in = (c % 2 == 0) ? 16'h9070 : 16'h1234;
      step("alternate", r, in, 16'h0790, !r && (c % 2 == 0),
           r ? 4'b0000 : ((c % 2 == 0) ? 4'b1111 : 4'b0000));
    end

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        logical[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                        : 4'($urandom_range(0, 9));
      in = logical;
      case ($urandom_range(0, 3))
        0: in = 16'($urandom);
        1: in[4*$urandom_range(0, 3) +: 4] = 4'($urandom);
        default: ;
      endcase
      r  = ($urandom_range(0, 19) == 0);
      dm = r ? 4'b0000 : model_dm(in, logical);
      step("random", r, in, scramble(logical), !r && (dm == 4'b1111), dm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
